// File: rtl/multicycle_control.sv
// Moore control FSM for the shared multicycle datapath; outputs registered from the next state, stalls MEM_LAT cycles per memory access.
// Optional macro OVERFLOW_TRAP_EN routes signed add/sub/addi overflow to EXCEPTION; undefined, overflow is ignored.
module multicycle_control #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       EPCWrite,
    output logic       Halted,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_FETCH_WB  = 4'd2,
        S_DECODE    = 4'd3,
        S_EXEC_R    = 4'd4,
        S_WB_R      = 4'd5,
        S_EXEC_I    = 4'd6,
        S_WB_I      = 4'd7,
        S_MEM_ADDR  = 4'd8,
        S_MEM_RD    = 4'd9,
        S_WB_MEM    = 4'd10,
        S_MEM_WR    = 4'd11,
        S_BRANCH    = 4'd12,
        S_JUMP      = 4'd13,
        S_EXCEPTION = 4'd14,
        S_HALT      = 4'd15
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       mdrwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       epcwrite;
        logic       halted;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SXORI = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_BREAK = 6'h0d;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [3:0] LAST_BEAT = 4'(MEM_LAT - 1);

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t ctrl_q, ctrl_d;
    logic stall_done;
    logic trap_r;
    logic trap_i;
    logic br_take;

`ifdef OVERFLOW_TRAP_EN
    assign trap_r = Overflow && (Funct == FN_ADD || Funct == FN_SUB);
    assign trap_i = Overflow && (Opcode == OP_ADDI);
`else
    logic unused_overflow;
    assign unused_overflow = Overflow;
    assign trap_r = 1'b0;
    assign trap_i = 1'b0;
`endif

    assign stall_done = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH:     if (stall_done) state_d = S_FETCH_WB;
            S_FETCH_WB:  state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE: begin
                        if (Funct == FN_BREAK)
                            state_d = S_HALT;
                        else if (Funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h26})
                            state_d = S_EXEC_R;
                        else
                            state_d = S_EXCEPTION;
                    end
                    OP_ADDI, OP_ADDIU, OP_SXORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:              state_d = S_BRANCH;
                    OP_J:                        state_d = S_JUMP;
                    default:                     state_d = S_EXCEPTION;
                endcase
            end
            S_EXEC_R:    state_d = trap_r ? S_EXCEPTION : S_WB_R;
            S_WB_R:      state_d = S_FETCH;
            S_EXEC_I:    state_d = trap_i ? S_EXCEPTION : S_WB_I;
            S_WB_I:      state_d = S_FETCH;
            S_MEM_ADDR:  state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    if (stall_done) state_d = S_WB_MEM;
            S_WB_MEM:    state_d = S_FETCH;
            S_MEM_WR:    if (stall_done) state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_EXCEPTION: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
        endcase
    end

    // Stall states only loop on themselves, so staying put means "still counting".
    always_comb begin
        cnt_d = 4'd0;
        if ((state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && state_d == state_q)
            cnt_d = cnt_q + 4'd1;
    end

    function automatic ctrl_t decode_ctrl(input state_t s, input logic last_beat, input logic sxori);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:     c.memread = 1'b1;
            S_FETCH_WB: begin
                c.irwrite = 1'b1;
                c.alusrcb = 2'b01;
                c.pcwrite = 1'b1;
            end
            S_DECODE:    c.alusrcb = 2'b11;
            S_EXEC_R: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'b010;
            end
            S_WB_R: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_EXEC_I: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = sxori ? 3'b011 : 3'b000;
            end
            S_WB_I:      c.regwrite = 1'b1;
            S_MEM_ADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEM_RD: begin
                c.iord     = 1'b1;
                c.memread  = 1'b1;
                c.mdrwrite = last_beat;
            end
            S_WB_MEM: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEM_WR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            // PCWrite here is the live branch condition, added at the output.
            S_BRANCH: begin
                c.alusrca  = 1'b1;
                c.aluop    = 3'b001;
                c.pcsource = 2'b01;
            end
            S_JUMP: begin
                c.pcsource = 2'b10;
                c.pcwrite  = 1'b1;
            end
            S_EXCEPTION: begin
                c.epcwrite = 1'b1;
                c.pcsource = 2'b11;
                c.pcwrite  = 1'b1;
            end
            S_HALT:      c.halted = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    assign ctrl_d = decode_ctrl(state_d, cnt_d == LAST_BEAT, Opcode == OP_SXORI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= 4'd0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign br_take  = (state_q == S_BRANCH) && ((Opcode == OP_BEQ) ? Zero : !Zero);
    assign PCWrite  = ctrl_q.pcwrite | br_take;
    assign IorD     = ctrl_q.iord;
    assign MemRead  = ctrl_q.memread;
    assign MemWrite = ctrl_q.memwrite;
    assign IRWrite  = ctrl_q.irwrite;
    assign MDRWrite = ctrl_q.mdrwrite;
    assign RegDst   = ctrl_q.regdst;
    assign MemtoReg = ctrl_q.memtoreg;
    assign RegWrite = ctrl_q.regwrite;
    assign ALUSrcA  = ctrl_q.alusrca;
    assign ALUSrcB  = ctrl_q.alusrcb;
    assign ALUOp    = ctrl_q.aluop;
    assign PCSource = ctrl_q.pcsource;
    assign EPCWrite = ctrl_q.epcwrite;
    assign Halted   = ctrl_q.halted;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle vector bench for multicycle_control at MEM_LAT=2 and MEM_LAT=3.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       Overflow;

    logic       PCWrite2, IorD2, MemRead2, MemWrite2, IRWrite2, MDRWrite2, RegDst2, MemtoReg2;
    logic       RegWrite2, ALUSrcA2, EPCWrite2, Halted2;
    logic [1:0] ALUSrcB2, PCSource2;
    logic [2:0] ALUOp2;
    logic [3:0] State2;
    logic       PCWrite3, IorD3, MemRead3, MemWrite3, IRWrite3, MDRWrite3, RegDst3, MemtoReg3;
    logic       RegWrite3, ALUSrcA3, EPCWrite3, Halted3;
    logic [1:0] ALUSrcB3, PCSource3;
    logic [2:0] ALUOp3;
    logic [3:0] State3;

    multicycle_control #(.MEM_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .Overflow(Overflow),
        .PCWrite(PCWrite2), .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2),
        .IRWrite(IRWrite2), .MDRWrite(MDRWrite2), .RegDst(RegDst2), .MemtoReg(MemtoReg2),
        .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2),
        .PCSource(PCSource2), .EPCWrite(EPCWrite2), .Halted(Halted2), .State(State2)
    );

    multicycle_control #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .Overflow(Overflow),
        .PCWrite(PCWrite3), .IorD(IorD3), .MemRead(MemRead3), .MemWrite(MemWrite3),
        .IRWrite(IRWrite3), .MDRWrite(MDRWrite3), .RegDst(RegDst3), .MemtoReg(MemtoReg3),
        .RegWrite(RegWrite3), .ALUSrcA(ALUSrcA3), .ALUSrcB(ALUSrcB3), .ALUOp(ALUOp3),
        .PCSource(PCSource3), .EPCWrite(EPCWrite3), .Halted(Halted3), .State(State3)
    );

    // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MDRWrite,RegDst,MemtoReg,RegWrite,EPCWrite,Halted,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    wire [18:0] ctl2 = {PCWrite2, IorD2, MemRead2, MemWrite2, IRWrite2, MDRWrite2, RegDst2, MemtoReg2,
                        RegWrite2, EPCWrite2, Halted2, ALUSrcA2, ALUSrcB2, ALUOp2, PCSource2};
    wire [18:0] ctl3 = {PCWrite3, IorD3, MemRead3, MemWrite3, IRWrite3, MDRWrite3, RegDst3, MemtoReg3,
                        RegWrite3, EPCWrite3, Halted3, ALUSrcA3, ALUSrcB3, ALUOp3, PCSource3};

    localparam logic [18:0] C_ZERO   = 19'b0_0_0_0_0_0_0_0_0_0_0_0_00_000_00;
    localparam logic [18:0] C_FETCH  = 19'b0_0_1_0_0_0_0_0_0_0_0_0_00_000_00;
    localparam logic [18:0] C_FWB    = 19'b1_0_0_0_1_0_0_0_0_0_0_0_01_000_00;
    localparam logic [18:0] C_DEC    = 19'b0_0_0_0_0_0_0_0_0_0_0_0_11_000_00;
    localparam logic [18:0] C_EXR    = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_010_00;
    localparam logic [18:0] C_WBR    = 19'b0_0_0_0_0_0_1_0_1_0_0_0_00_000_00;
    localparam logic [18:0] C_EXI    = 19'b0_0_0_0_0_0_0_0_0_0_0_1_10_000_00;
    localparam logic [18:0] C_EXI_X  = 19'b0_0_0_0_0_0_0_0_0_0_0_1_10_011_00;
    localparam logic [18:0] C_WBI    = 19'b0_0_0_0_0_0_0_0_1_0_0_0_00_000_00;
    localparam logic [18:0] C_MADDR  = 19'b0_0_0_0_0_0_0_0_0_0_0_1_10_000_00;
    localparam logic [18:0] C_MRD    = 19'b0_1_1_0_0_0_0_0_0_0_0_0_00_000_00;
    localparam logic [18:0] C_MRD_L  = 19'b0_1_1_0_0_1_0_0_0_0_0_0_00_000_00;
    localparam logic [18:0] C_WBM    = 19'b0_0_0_0_0_0_0_1_1_0_0_0_00_000_00;
    localparam logic [18:0] C_MWR    = 19'b0_1_0_1_0_0_0_0_0_0_0_0_00_000_00;
    localparam logic [18:0] C_BR_T   = 19'b1_0_0_0_0_0_0_0_0_0_0_1_00_001_01;
    localparam logic [18:0] C_BR_N   = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_001_01;
    localparam logic [18:0] C_JMP    = 19'b1_0_0_0_0_0_0_0_0_0_0_0_00_000_10;
    localparam logic [18:0] C_EXC    = 19'b1_0_0_0_0_0_0_0_0_1_0_0_00_000_11;
    localparam logic [18:0] C_HALT   = 19'b0_0_0_0_0_0_0_0_0_0_1_0_00_000_00;

    localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1,  ST_FWB  = 4'd2,  ST_DEC  = 4'd3;
    localparam logic [3:0] ST_EXR   = 4'd4,  ST_WBR   = 4'd5,  ST_EXI  = 4'd6,  ST_WBI  = 4'd7;
    localparam logic [3:0] ST_MADDR = 4'd8,  ST_MRD   = 4'd9,  ST_WBM  = 4'd10, ST_MWR  = 4'd11;
    localparam logic [3:0] ST_BR    = 4'd12, ST_JMP   = 4'd13, ST_EXC  = 4'd14, ST_HALT = 4'd15;

`ifdef OVERFLOW_TRAP_EN
    localparam logic [3:0]  ST_R_OV = ST_EXC;
    localparam logic [18:0] C_R_OV  = C_EXC;
    localparam logic [3:0]  ST_I_OV = ST_EXC;
    localparam logic [18:0] C_I_OV  = C_EXC;
`else
    localparam logic [3:0]  ST_R_OV = ST_WBR;
    localparam logic [18:0] C_R_OV  = C_WBR;
    localparam logic [3:0]  ST_I_OV = ST_WBI;
    localparam logic [18:0] C_I_OV  = C_WBI;
`endif

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ov;
        logic        sel;
        logic [3:0]  st;
        logic [18:0] ctl;
    } vec_t;

    vec_t vq[$];
    int   total;
    int   bad;
    int   row_no;

    logic       cur_sel;
    logic [5:0] cur_op, cur_fn;
    logic       cur_z, cur_ov;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input logic rst, input logic [3:0] st, input logic [18:0] ctl);
        vec_t v;
        v.rst = rst; v.op = cur_op; v.fn = cur_fn; v.z = cur_z; v.ov = cur_ov;
        v.sel = cur_sel; v.st = st; v.ctl = ctl;
        vq.push_back(v);
    endtask

    task automatic step(input logic [3:0] st, input logic [18:0] ctl);
        push(1'b0, st, ctl);
    endtask

    task automatic rst_row(input logic sel);
        cur_sel = sel;
        push(1'b1, ST_RESET, C_ZERO);
    endtask

    // Common front end of every instruction: lat FETCH cycles, FETCH_WB, DECODE.
    task automatic begin_instr(input logic sel, input int lat, input logic [5:0] op,
                               input logic [5:0] fn, input logic z, input logic ov);
        cur_sel = sel; cur_op = op; cur_fn = fn; cur_z = z; cur_ov = ov;
        for (int i = 0; i < lat; i++) step(ST_FETCH, C_FETCH);
        step(ST_FWB, C_FWB);
        step(ST_DEC, C_DEC);
    endtask

    task automatic check(input string name, input logic [3:0] want_st, input logic [18:0] want_ctl,
                         input logic sel);
        logic [3:0]  act_st;
        logic [18:0] act_ctl;
        act_st  = sel ? State3 : State2;
        act_ctl = sel ? ctl3 : ctl2;
        total++;
        if (act_st !== want_st) begin
            bad++;
            $display("FAIL %s state: got %0d want %0d", name, act_st, want_st);
        end
        total++;
        if (act_ctl !== want_ctl) begin
            bad++;
            $display("FAIL %s ctl: got %b want %b", name, act_ctl, want_ctl);
        end
    endtask

    task automatic run_table();
        foreach (vq[i]) begin
            reset    = vq[i].rst;
            Opcode   = vq[i].op;
            Funct    = vq[i].fn;
            Zero     = vq[i].z;
            Overflow = vq[i].ov;
            @(posedge clk);
            #2;
            check($sformatf("row%0d", row_no), vq[i].st, vq[i].ctl, vq[i].sel);
            row_no++;
        end
        vq.delete();
    endtask

    initial begin
        total = 0; bad = 0; row_no = 0;
        reset = 1'b1; Opcode = '0; Funct = '0; Zero = 1'b0; Overflow = 1'b0;
        cur_sel = 1'b0; cur_op = '0; cur_fn = '0; cur_z = 1'b0; cur_ov = 1'b0;

        rst_row(1'b0);
        rst_row(1'b0);
        begin_instr(1'b0, 2, 6'h00, 6'h20, 1'b0, 1'b0);  // add
        step(ST_EXR, C_EXR);  step(ST_WBR, C_WBR);
        begin_instr(1'b0, 2, 6'h00, 6'h21, 1'b0, 1'b1);  // addu, overflow ignored
        step(ST_EXR, C_EXR);  step(ST_WBR, C_WBR);
        begin_instr(1'b0, 2, 6'h00, 6'h20, 1'b0, 1'b1);  // add, overflow
        step(ST_EXR, C_EXR);  step(ST_R_OV, C_R_OV);
        begin_instr(1'b0, 2, 6'h00, 6'h22, 1'b0, 1'b1);  // sub, overflow
        step(ST_EXR, C_EXR);  step(ST_R_OV, C_R_OV);
        begin_instr(1'b0, 2, 6'h00, 6'h26, 1'b0, 1'b0);  // xor
        step(ST_EXR, C_EXR);  step(ST_WBR, C_WBR);
        begin_instr(1'b0, 2, 6'h04, 6'h00, 1'b1, 1'b0);  // beq taken
        step(ST_BR, C_BR_T);
        begin_instr(1'b0, 2, 6'h04, 6'h00, 1'b0, 1'b0);  // beq not taken
        step(ST_BR, C_BR_N);
        begin_instr(1'b0, 2, 6'h05, 6'h00, 1'b0, 1'b0);  // bne taken
        step(ST_BR, C_BR_T);
        begin_instr(1'b0, 2, 6'h05, 6'h00, 1'b1, 1'b0);  // bne not taken
        step(ST_BR, C_BR_N);
        begin_instr(1'b0, 2, 6'h02, 6'h00, 1'b0, 1'b0);  // j
        step(ST_JMP, C_JMP);
        begin_instr(1'b0, 2, 6'h0e, 6'h00, 1'b0, 1'b0);  // sxori
        step(ST_EXI, C_EXI_X);  step(ST_WBI, C_WBI);
        begin_instr(1'b0, 2, 6'h08, 6'h00, 1'b0, 1'b1);  // addi, overflow
        step(ST_EXI, C_EXI);  step(ST_I_OV, C_I_OV);
        begin_instr(1'b0, 2, 6'h09, 6'h00, 1'b0, 1'b1);  // addiu never traps
        step(ST_EXI, C_EXI);  step(ST_WBI, C_WBI);
        begin_instr(1'b0, 2, 6'h2b, 6'h00, 1'b0, 1'b0);  // sw
        step(ST_MADDR, C_MADDR);  step(ST_MWR, C_MWR);  step(ST_MWR, C_MWR);
        begin_instr(1'b0, 2, 6'h23, 6'h00, 1'b0, 1'b0);  // lw
        step(ST_MADDR, C_MADDR);  step(ST_MRD, C_MRD);  step(ST_MRD, C_MRD_L);  step(ST_WBM, C_WBM);
        begin_instr(1'b0, 2, 6'h3f, 6'h00, 1'b0, 1'b0);  // illegal opcode
        step(ST_EXC, C_EXC);
        begin_instr(1'b0, 2, 6'h00, 6'h27, 1'b0, 1'b0);  // illegal funct
        step(ST_EXC, C_EXC);
        begin_instr(1'b0, 2, 6'h00, 6'h0d, 1'b0, 1'b0);  // BREAK
        step(ST_HALT, C_HALT);
        run_table();

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("halt_hold%0d", i), ST_HALT, C_HALT, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("halt_reset", ST_RESET, C_ZERO, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("after_reset", ST_FETCH, C_FETCH, 1'b0);

        rst_row(1'b1);
        begin_instr(1'b1, 3, 6'h23, 6'h00, 1'b0, 1'b0);  // lw at MEM_LAT=3
        step(ST_MADDR, C_MADDR);  step(ST_MRD, C_MRD);  step(ST_MRD, C_MRD);
        step(ST_MRD, C_MRD_L);    step(ST_WBM, C_WBM);
        rst_row(1'b0);
        begin_instr(1'b0, 2, 6'h23, 6'h00, 1'b0, 1'b0);  // lw cut short by reset mid-stall
        step(ST_MADDR, C_MADDR);  step(ST_MRD, C_MRD);
        rst_row(1'b0);
        step(ST_FETCH, C_FETCH);
        run_table();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences the shared multicycle datapath: one ALU, one memory port, the IR, the register file and the PC.
- Decodes Opcode and Funct, then issues per-cycle datapath controls, including the 3-bit ALUOp consumed by the ALU control decoder.
- Stalls on fixed-latency memory accesses, handles BREAK halt, and traps on signed overflow and illegal opcodes.

Parameters:
- MEM_LAT, 2, cycles the memory port needs per access (legal range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- Opcode  in  6  IR[31:26], valid from DECODE onward.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag, combinational.
- Overflow  in  1  ALU signed overflow, combinational.
- PCWrite  out  1  PC load enable; branch condition is already folded in.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load enable.
- MDRWrite  out  1  memory data register load enable.
- RegDst  out  1  register write address: 0 = rt, 1 = rd.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  3  000 add, 001 sub, 010 use Funct, 011 xor.
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- EPCWrite  out  1  EPC load enable.
- Halted  out  1  high in HALT.
- State  out  4  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: the first clk edge with reset high puts the FSM in RESET. In RESET all outputs are 0. Reset overrides every state, including mid-stall and HALT. RESET goes to FETCH unconditionally.
- All control outputs are decoded purely from the state, except PCWrite in BRANCH. Any output not listed for a state is 0.
- Stall counter: 4-bit, cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle in those states. The state exits when count == MEM_LAT-1. MemRead/MemWrite stay high for exactly MEM_LAT consecutive cycles.
- FETCH: IorD=0, MemRead. Exits to FETCH_WB.
- FETCH_WB: IRWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00, PCWrite. PC becomes PC+4. Goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Next state by opcode:
  - 0x00 R-type: BREAK if Funct==0x0d → HALT; Funct in {20,21,22,23,24,26} → EXEC_R; any other Funct → EXCEPTION.
  - 0x08 addi, 0x09 addiu, 0x0e sxori → EXEC_I.
  - 0x23 lw, 0x2b sw → MEM_ADDR.
  - 0x04 beq, 0x05 bne → BRANCH.
  - 0x02 j → JUMP.
  - anything else → EXCEPTION.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Goes to EXCEPTION if Overflow && Funct in {0x20,0x22}; otherwise WB_R. Unsigned forms (0x21, 0x23) never trap.
- WB_R: RegDst=1, MemtoReg=0, RegWrite. Goes to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp=011 for sxori, 000 otherwise. Goes to EXCEPTION if Overflow && opcode 0x08; otherwise WB_I.
- WB_I: RegDst=0, MemtoReg=0, RegWrite. Goes to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. lw → MEM_RD, sw → MEM_WR.
- MEM_RD: IorD=1, MemRead, MDRWrite on the last stall cycle. Exits to WB_MEM.
- WB_MEM: RegDst=0, MemtoReg=1, RegWrite. Goes to FETCH.
- MEM_WR: IorD=1, MemWrite. Exits to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWrite = Zero for beq, !Zero for bne. Goes to FETCH.
- JUMP: PCSource=10, PCWrite. Goes to FETCH.
- EXCEPTION: EPCWrite, PCSource=11, PCWrite. EPC captures the already-incremented PC. No RegWrite occurs for a trapping instruction. Goes to FETCH.
- HALT: Halted=1, all other outputs 0. Only reset leaves HALT.
- Cycle counts with MEM_LAT=L:
  - R-type / I-type: L+4.
  - lw: 2L+4.
  - sw: 2L+3.
  - beq / bne / j: L+3.
  - Trap: the path up to the EXEC stage, plus 1 cycle in EXCEPTION.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- Defined: overflow traps as specified above.
- Undefined: Overflow is ignored; add, sub and addi always proceed to WB and write the wrapped result. Illegal opcodes and illegal Funct values still go to EXCEPTION.

Test Plan:
- Reset, then an add with no overflow, MEM_LAT=2 → exactly 6 cycles FETCH..WB_R; RegWrite=1, RegDst=1 for one cycle in WB_R; ALUOp=010 in EXEC_R.
- lw with MEM_LAT=3 → MemRead high for 3 cycles in FETCH and 3 cycles in MEM_RD; MDRWrite high only in the 3rd MEM_RD cycle; 10 cycles total.
- beq with Zero=1, then beq with Zero=0 → PCWrite=1 with PCSource=01 only in the first case; bne with Zero=0 → PCWrite=1.
- add with Overflow=1 (macro defined) → EXCEPTION with EPCWrite=1, PCSource=11, no RegWrite. addu with Overflow=1 → normal WB_R. Macro undefined: add with Overflow=1 → WB_R writes.
- Funct=0x0d → HALT, Halted=1 held for 20 cycles; reset pulse → RESET, then FETCH.
- Opcode 0x3f → EXCEPTION. Reset asserted mid MEM_RD stall → RESET on the next edge, all outputs 0.
